// File: rtl/alu_arb_sched_4b.sv
// -----------------------------------------------------------------------------
// alu_arb_sched_4b
//
// Two-requester round-robin front end for a shared 4-bit ALU whose output
// stage is a one-cycle register outside this block. One operation is in
// flight at a time: IDLE -> EXEC -> CAPT -> RESP -> IDLE.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   req{0,1}_valid/_ready        request handshake (ready only in IDLE)
//   req{0,1}_a/_b/_op            operands and opcode of each requester
//   alu_a, alu_b, alu_op         latched operands/opcode driven to the ALU
//   alu_f, alu_cout              registered ALU result and carry
//   rsp_valid/rsp_ready          response handshake
//   rsp_id, rsp_f, rsp_cout      owner, captured result and carry
//   busy                         high whenever not IDLE
//   op_count                     completed responses, saturating at 8'hFF
// -----------------------------------------------------------------------------
module alu_arb_sched_4b #(
   parameter int unsigned FIRST_REQ = 0,
   parameter int unsigned OPW       = 3
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [3:0]     req0_a,
   input  logic [3:0]     req0_b,
   input  logic [OPW-1:0] req0_op,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [3:0]     req1_a,
   input  logic [3:0]     req1_b,
   input  logic [OPW-1:0] req1_op,
   output logic [3:0]     alu_a,
   output logic [3:0]     alu_b,
   output logic [OPW-1:0] alu_op,
   input  logic [3:0]     alu_f,
   input  logic           alu_cout,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [3:0]     rsp_f,
   output logic           rsp_cout,
   output logic           busy,
   output logic [7:0]     op_count
);

   typedef enum logic [1:0] {StIdle, StExec, StCapt, StResp} state_e;

   // The pointer holds the last winner; a contest goes to the other side, so
   // resetting it to the opposite of FIRST_REQ makes FIRST_REQ win first.
   localparam logic LastInit = (FIRST_REQ == 0) ? 1'b1 : 1'b0;

   state_e         state_q, state_d;
   logic           last_q, last_d;
   logic [3:0]     a_q, a_d;
   logic [3:0]     b_q, b_d;
   logic [OPW-1:0] op_q, op_d;
   logic           id_q, id_d;
   logic [3:0]     f_q, f_d;
   logic           cout_q, cout_d;
   logic [7:0]     cnt_q, cnt_d;

   logic any_valid;
   logic gnt_id;
   logic accept;
   logic rsp_hs;

   // Arbitration: a lone requester wins outright; a contest goes to the side
   // that did not win last time.
   always_comb begin
      any_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         gnt_id = ~last_q;
      end else begin
         gnt_id = req1_valid;
      end
      // reset_n gates acceptance so nothing is handed off while in reset.
      accept = (state_q == StIdle) && any_valid && reset_n;
      rsp_hs = (state_q == StResp) && rsp_ready;
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      id_d    = id_q;
      f_d     = f_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StExec;
               last_d  = gnt_id;
               id_d    = gnt_id;
               a_d     = gnt_id ? req1_a  : req0_a;
               b_d     = gnt_id ? req1_b  : req0_b;
               op_d    = gnt_id ? req1_op : req0_op;
            end
         end
         StExec: begin
            state_d = StCapt;
         end
         StCapt: begin
            // alu_f now holds the result registered at the end of EXEC.
            state_d = StResp;
            f_d     = alu_f;
            cout_d  = alu_cout;
         end
         StResp: begin
            if (rsp_hs) begin
               state_d = StIdle;
               if (cnt_q != 8'hFF) begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         last_q  <= LastInit;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         id_q    <= 1'b0;
         f_q     <= '0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         id_q    <= id_d;
         f_q     <= f_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   // ALU inputs come only from the latched copy, so they never follow the
   // requester buses.
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_op     = op_q;
   assign req0_ready = accept & ~gnt_id;
   assign req1_ready = accept & gnt_id;
   assign rsp_valid  = (state_q == StResp);
   assign rsp_id     = id_q;
   assign rsp_f      = f_q;
   assign rsp_cout   = cout_q;
   assign busy       = (state_q != StIdle);
   assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_arb_sched_4b.sv
module tb_alu_arb_sched_4b;

   localparam int unsigned OPW = 3;
   localparam logic LAST_INIT = 1'b1; // FIRST_REQ = 0 wins the first contest

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           req0_valid = 1'b0, req1_valid = 1'b0;
   logic           req0_ready, req1_ready;
   logic [3:0]     req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [OPW-1:0] req0_op = '0, req1_op = '0;
   logic [3:0]     alu_a, alu_b, alu_f;
   logic [OPW-1:0] alu_op;
   logic           alu_cout;
   logic           rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_cout, busy;
   logic [3:0]     rsp_f;
   logic [7:0]     op_count;
   logic [4:0]     alu_res = '0;

   always #5 clk = ~clk;

   alu_arb_sched_4b #(.FIRST_REQ(0), .OPW(OPW)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_f(alu_f), .alu_cout(alu_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_f(rsp_f), .rsp_cout(rsp_cout), .busy(busy), .op_count(op_count)
   );

   // ALU: op 0 is ADD; result is {carry, f}.
   function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [OPW-1:0] op);
      case (op)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {1'b0, a} - {1'b0, b};
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, a ^ b};
         3'd5:    return {1'b0, ~a};
         3'd6:    return {a, 1'b0};
         default: return {1'b0, b};
      endcase
   endfunction

   // External one-cycle registered ALU stage.
   always @(posedge clk) alu_res <= alu_fn(alu_a, alu_b, alu_op);
   assign alu_f    = alu_res[3:0];
   assign alu_cout = alu_res[4];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Stimulus for the next cycle.
   logic           s_v0 = 0, s_v1 = 0, s_rr = 0;
   logic [3:0]     s_a0 = 0, s_b0 = 0, s_a1 = 0, s_b1 = 0;
   logic [OPW-1:0] s_op0 = 0, s_op1 = 0;

   // Transaction-level reference: one op in flight, response 3 cycles after
   // acceptance, round-robin on contests.
   int             cyc = 0;
   int             m_acc = 0;
   logic           m_busy = 0;
   logic           m_last = LAST_INIT;
   logic           m_id = 0;
   logic [3:0]     m_f = 0;
   logic           m_cout = 0;
   logic [7:0]     m_cnt = 0;
   logic [3:0]     m_alu_a = 0, m_alu_b = 0;
   logic [OPW-1:0] m_alu_op = 0;
   logic           gnt_log[$];
   logic           rsp_log[$];

   task automatic cycle();
      logic idle, g, r0, r1, in_rsp;
      @(negedge clk);
      req0_valid = s_v0; req0_a = s_a0; req0_b = s_b0; req0_op = s_op0;
      req1_valid = s_v1; req1_a = s_a1; req1_b = s_b1; req1_op = s_op1;
      rsp_ready  = s_rr;
      #1;
      idle   = !m_busy;
      g      = (s_v0 && s_v1) ? !m_last : s_v1;
      r0     = idle && (s_v0 || s_v1) && !g;
      r1     = idle && (s_v0 || s_v1) && g;
      in_rsp = m_busy && (cyc >= m_acc + 3);
      check_eq("req0_ready", req0_ready, r0);
      check_eq("req1_ready", req1_ready, r1);
      check_eq("busy", busy, m_busy);
      check_eq("rsp_valid", rsp_valid, in_rsp);
      check_eq("op_count", op_count, m_cnt);
      check_eq("alu_a", alu_a, m_alu_a);
      check_eq("alu_b", alu_b, m_alu_b);
      check_eq("alu_op", alu_op, m_alu_op);
      if (in_rsp) begin
         check_eq("rsp_id", rsp_id, m_id);
         check_eq("rsp_f", rsp_f, m_f);
         check_eq("rsp_cout", rsp_cout, m_cout);
      end
      if (req0_ready && req0_valid) gnt_log.push_back(1'b0);
      if (req1_ready && req1_valid) gnt_log.push_back(1'b1);
      if (rsp_valid && rsp_ready) rsp_log.push_back(rsp_id);
      if (r0 || r1) begin
         m_busy   = 1'b1;
         m_acc    = cyc;
         m_last   = g;
         m_id     = g;
         m_alu_a  = g ? s_a1 : s_a0;
         m_alu_b  = g ? s_b1 : s_b0;
         m_alu_op = g ? s_op1 : s_op0;
         {m_cout, m_f} = alu_fn(m_alu_a, m_alu_b, m_alu_op);
      end else if (in_rsp && s_rr) begin
         m_busy = 1'b0;
         if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
      cyc++;
   endtask

   // Asserts reset shortly after a rising edge and releases it just after a
   // later rising edge, so the following cycle() edge is the first one.
   task automatic apply_reset();
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      check_eq("rst rsp_valid", rsp_valid, 1'b0);
      check_eq("rst busy", busy, 1'b0);
      check_eq("rst rsp_id", rsp_id, 1'b0);
      check_eq("rst rsp_f", rsp_f, 4'h0);
      check_eq("rst rsp_cout", rsp_cout, 1'b0);
      check_eq("rst alu_a", alu_a, 4'h0);
      check_eq("rst alu_b", alu_b, 4'h0);
      check_eq("rst alu_op", alu_op, '0);
      check_eq("rst op_count", op_count, 8'h00);
      check_eq("rst req0_ready", req0_ready, 1'b0);
      check_eq("rst req1_ready", req1_ready, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst hold busy", busy, 1'b0);
      check_eq("rst hold req0_ready", req0_ready, 1'b0);
      reset_n  = 1'b1;
      m_busy   = 1'b0;
      m_last   = LAST_INIT;
      m_cnt    = '0;
      m_alu_a  = '0;
      m_alu_b  = '0;
      m_alu_op = '0;
   endtask

   initial begin
      // Reset state and a single ADD from req0: 7 + 5 = C, no carry.
      apply_reset();
      s_v0 = 1; s_a0 = 4'h7; s_b0 = 4'h5; s_op0 = 3'd0; s_rr = 1;
      cycle();
      s_v0 = 0;
      repeat (5) cycle();
      check_eq("single op_count", op_count, 8'd1);

      // Both valid continuously from reset: grants and responses alternate.
      apply_reset();
      gnt_log.delete();
      rsp_log.delete();
      s_v0 = 1; s_v1 = 1; s_a0 = 4'h2; s_b0 = 4'h3; s_a1 = 4'h9; s_b1 = 4'h4;
      s_op0 = 3'd0; s_op1 = 3'd4; s_rr = 1;
      repeat (18) cycle();
      s_v0 = 0; s_v1 = 0;
      repeat (4) cycle();
      check_eq("gnt_log size", gnt_log.size() >= 4, 1'b1);
      check_eq("rsp_log size", rsp_log.size() >= 4, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (i < gnt_log.size()) check_eq("gnt alternate", gnt_log[i], i % 2);
         if (i < rsp_log.size()) check_eq("rsp_id alternate", rsp_log[i], i % 2);
      end

      // Consumer stalls in RESP: everything holds, no new acceptance.
      s_v1 = 1; s_a1 = 4'hA; s_b1 = 4'h6; s_op1 = 3'd1; s_rr = 0;
      cycle();
      s_v0 = 1;
      repeat (8) begin
         s_a0 = 4'($urandom); s_b0 = 4'($urandom);
         cycle();
      end
      s_v0 = 0; s_v1 = 0; s_rr = 1;
      repeat (3) cycle();

      // Reset in CAPT drops the in-flight op without a response.
      apply_reset();
      s_v0 = 1; s_a0 = 4'hE; s_b0 = 4'h3; s_op0 = 3'd0; s_rr = 1;
      cycle();              // accept
      s_v0 = 0;
      cycle();              // EXEC
      apply_reset();        // lands in CAPT
      repeat (4) cycle();
      check_eq("capt reset op_count", op_count, 8'd0);

      // req1 alone; req0 operands wiggle during EXEC without effect.
      s_v1 = 1; s_a1 = 4'h3; s_b1 = 4'h9; s_op1 = 3'd3;
      cycle();
      s_v1 = 0;
      repeat (4) begin
         s_a0 = 4'($urandom); s_b0 = 4'($urandom); s_a1 = 4'($urandom);
         cycle();
      end

      // 260 back-to-back F + 1: zero with carry; count saturates at FF.
      apply_reset();
      s_v0 = 1; s_v1 = 0; s_a0 = 4'hF; s_b0 = 4'h1; s_op0 = 3'd0; s_rr = 1;
      repeat (260 * 4) cycle();
      s_v0 = 0;
      repeat (4) cycle();
      check_eq("saturated op_count", op_count, 8'hFF);

      // Randomised traffic.
      apply_reset();
      repeat (3000) begin
         s_v0  = ($urandom_range(0, 2) != 0);
         s_v1  = ($urandom_range(0, 2) != 0);
         s_a0  = 4'($urandom); s_b0 = 4'($urandom); s_op0 = OPW'($urandom);
         s_a1  = 4'($urandom); s_b1 = 4'($urandom); s_op1 = OPW'($urandom);
         s_rr  = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_arb_sched_4b.md
ALU_ARB_SCHED_4B -- requirements
Module: alu_arb_sched_4b

Interface
REQ-001 Parameter FIRST_REQ, default 0: requester that wins the first contested arbitration after reset (0 or 1).
REQ-002 Parameter OPW, default 3: width of the ALU opcode field.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset; no other clock or reset exists.
REQ-005 req0_valid / req1_valid  input  1  requester 0/1 presents an operation.
REQ-006 req0_ready / req1_ready  output  1  requester 0/1 operation accepted this cycle (accept = valid && ready).
REQ-007 req0_a, req0_b, req1_a, req1_b  input  4  operands of each requester.
REQ-008 req0_op, req1_op  input  OPW  opcode of each requester.
REQ-009 alu_a, alu_b  output  4  operands driven to the combinational ALU.
REQ-010 alu_op  output  OPW  opcode driven to the ALU.
REQ-011 alu_f  input  4  result from the registered ALU output stage (one-cycle register).
REQ-012 alu_cout  input  1  carry from the registered ALU output stage.
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_ready  input  1  consumer takes the result (handshake = rsp_valid && rsp_ready).
REQ-015 rsp_id  output  1  requester that owns the result.
REQ-016 rsp_f  output  4, rsp_cout  output  1  captured result and carry.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 op_count  output  8  number of completed responses, saturating.

Function
REQ-019 FSM states SHALL be IDLE, EXEC, CAPT, RESP; exactly one active at a time.
REQ-020 IDLE: if any reqN_valid, SHALL assert ready to exactly one requester (combinational, same cycle) and go to EXEC on that edge; otherwise stay in IDLE.
REQ-021 Arbitration: only one valid -> grant it; both valid -> grant the requester not granted last; last-grant pointer updates only on acceptance.
REQ-022 On acceptance, operands, opcode and granted id SHALL be latched internally; requester inputs are ignored afterwards.
REQ-023 reqN_ready SHALL be 0 in EXEC, CAPT and RESP, so there is no acceptance while busy.
REQ-024 EXEC: alu_a/alu_b/alu_op SHALL drive the latched values; the ALU stage registers the result on the edge ending EXEC; next state CAPT.
REQ-025 CAPT: SHALL register alu_f/alu_cout into rsp_f/rsp_cout on the edge ending CAPT; next state RESP.
REQ-026 In IDLE, CAPT and RESP, alu_a/alu_b/alu_op SHALL keep the last latched values (no glitching to requester inputs).
REQ-027 RESP: rsp_valid=1; rsp_id/rsp_f/rsp_cout SHALL be stable until the handshake; on handshake -> IDLE; no handshake -> hold.
REQ-028 Latency: acceptance at edge k SHALL give rsp_valid=1 in the cycle after edge k+2, so a new acceptance is possible no earlier than the cycle after the rsp handshake.
REQ-029 op_count SHALL increment on each rsp handshake and hold at 8'hFF.
REQ-030 rsp_valid SHALL be 0 in all states other than RESP.

Reset
REQ-031 reset_n low SHALL immediately (asynchronously) force state=IDLE, rsp_valid=0, rsp_id=0, rsp_f=4'h0, rsp_cout=0, alu_a=alu_b=0, alu_op=0, op_count=0, busy=0; last-grant pointer SHALL be set so FIRST_REQ wins the next contest.
REQ-032 Reset asserted mid-operation (EXEC/CAPT/RESP) SHALL drop the in-flight operation without a response; no acceptance SHALL occur while reset_n is low.
REQ-033 After reset_n deasserts, first acceptance SHALL be possible on the first rising edge.

Verification
REQ-034 req0 only, a=4'h7, b=4'h5, op=ADD, rsp_ready=1 -> req0_ready one cycle, rsp_valid 3 cycles later with rsp_id=0, rsp_f=4'hC, rsp_cout=0, op_count=1.
REQ-035 Both valid continuously from reset, FIRST_REQ=0 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1.
REQ-036 rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_f, rsp_id constant, both readies 0, busy=1; release -> IDLE next cycle.
REQ-037 reset_n pulsed low during CAPT -> outputs at reset values immediately, no response produced, op_count unchanged at 0.
REQ-038 256 back-to-back operations, a=4'hF, b=4'h1, ADD -> each rsp_f=4'h0, rsp_cout=1; op_count saturates at 8'hFF.
REQ-039 req1 valid alone while req0 changes operands during EXEC -> alu_a/alu_b unchanged, result uses the latched req1 operands.
